// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver FSM states, default
// line/clock constants and helpers that size the baud-tick divider.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } rx_state_e;

    localparam int unsigned FREQ_DEFAULT = 12_000_000;
    localparam int unsigned BAUD_DEFAULT = 9600;
    localparam int unsigned OS_DEFAULT   = 16;

    // Clock cycles per oversample tick; the remainder is truncated.
    function automatic int unsigned calc_div(input int unsigned freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return freq / (baud * os);
    endfunction

    // Width of a counter running 0..div-1 (at least one bit).
    function automatic int unsigned calc_cnt_w(input int unsigned div);
        return (div <= 1) ? 1 : int'($clog2(div));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the receive and transmit sides.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (counter -> 0)
//   restart_i  forces the counter to 0 so tick phase follows an external event
//   tick_o     one-cycle pulse every DIV clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV   = 78,
    parameter int unsigned CNT_W = calc_cnt_w(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    // A restart suppresses the tick so no stale phase leaks into the new frame.
    assign tick_o  = at_last && !restart_i;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with 3-sample majority voting and a
// one-deep valid/ready holding register.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   rx_data    received byte, stable while rx_valid
//   rx_valid   byte available, held until rx_ready
//   rx_ready   downstream accept
//   frame_err  one-cycle pulse when the stop bit is sampled 0
//   overrun    one-cycle pulse when a finished byte is dropped
//   rx_busy    FSM not idle
//
// state   | meaning
// IDLE    | line idle, waiting for a synchronised falling edge
// START   | validating start bit by majority at mid-bit
// DATA    | shifting in 8 data bits, LSB first
// STOP    | sampling stop bit; byte delivered at mid-stop
// WAIT_HI | stop bit was 0 (break); wait for line to return high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned FREQ = FREQ_DEFAULT,
    parameter int unsigned BAUD = BAUD_DEFAULT,
    parameter int unsigned OS   = OS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned DIV  = calc_div(FREQ, BAUD, OS);
    localparam int unsigned OS_W = $clog2(OS);

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS - 1);
    localparam logic [OS_W-1:0] SMP_A   = OS_W'(OS / 2 - 1);
    localparam logic [OS_W-1:0] SMP_B   = OS_W'(OS / 2);
    localparam logic [OS_W-1:0] SMP_C   = OS_W'(OS / 2 + 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    rx_state_e       state_q;
    logic [OS_W-1:0] os_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            smp_a_q;
    logic            smp_b_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic tick;
    logic restart;
    logic resolve;
    logic wrap;
    logic maj;

    assign restart = (state_q == IDLE) && !rx_s_q;
    assign resolve = tick && (os_cnt_q == SMP_C);
    assign wrap    = tick && (os_cnt_q == OS_LAST);
    // Third sample is the live synchronised value on the resolving tick.
    assign maj     = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            smp_a_q     <= 1'b1;
            smp_b_q     <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Accept; a same-cycle delivery below overrides this.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (tick && state_q != IDLE) begin
                os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
                if (os_cnt_q == SMP_A) smp_a_q <= rx_s_q;
                if (os_cnt_q == SMP_B) smp_b_q <= rx_s_q;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q  <= START;
                        os_cnt_q <= '0;
                    end
                end
                START: begin
                    if (resolve && maj) begin
                        state_q <= IDLE;
                    end else if (wrap) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    if (resolve) begin
                        shift_q <= {maj, shift_q[7:1]};
                    end
                    if (wrap) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a directly following start edge is seen.
                    if (resolve) begin
                        if (maj) begin
                            state_q <= IDLE;
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os. Clock and bit rate are chosen so that
// DIV divides exactly (10 clocks per tick, 160 clocks per bit), which keeps
// frames short while exercising the same oversampling logic.
module tb_uart_rx_os;

    localparam int unsigned TB_FREQ = 12_000_000;
    localparam int unsigned TB_BAUD = 75_000;
    localparam int unsigned TB_OS   = 16;
    localparam int BIT_CYC  = TB_FREQ / TB_BAUD;      // 160
    localparam int SKEW_CYC = (BIT_CYC * 40) / 41;    // +2.5% faster line: 156

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int valid_cycles = 0;
    int fe_count = 0;
    int ov_count = 0;
    int pushed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    uart_rx_os #(
        .FREQ (TB_FREQ),
        .BAUD (TB_BAUD),
        .OS   (TB_OS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid)  valid_cycles++;
            if (frame_err) fe_count++;
            if (overrun)   ov_count++;
            if (rx_valid && rx_ready) begin
                accepts++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_byte_unexpected: got %02h, required no byte", rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rx_data !== mon_exp) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h, required %02h", rx_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bc,
                              input logic stop_v, input int stop_len);
        rx = 1'b0;
        step(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(bc);
        end
        rx = stop_v;
        step(stop_len);
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        step(3);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b, required 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h, required 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %0b, required 0", rx_busy); end
        checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %02b, required 00", {frame_err, overrun}); end
        rst = 1'b0;
        step(4);
    endtask

    task automatic test_single_byte();
        int a0, v0, f0, o0;
        rx_ready = 1'b1;
        a0 = accepts; v0 = valid_cycles; f0 = fe_count; o0 = ov_count;
        push_exp(8'h55);
        send_frame(8'h55, BIT_CYC, 1'b1, BIT_CYC);
        step(10);
        checks++; if (accepts - a0 != 1) begin errors++; $display("FAIL single_accepts: got %0d, required 1", accepts - a0); end
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d, required 1", valid_cycles - v0); end
        checks++; if (fe_count - f0 != 0 || ov_count - o0 != 0) begin errors++; $display("FAIL single_errs: got fe=%0d ov=%0d, required 0 0", fe_count - f0, ov_count - o0); end
    endtask

    task automatic test_glitch();
        int a0;
        a0 = accepts;
        rx = 1'b0;
        step(5);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %0b, required 1", rx_busy); end
        step(15);
        rx = 1'b1;
        step(100);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %0b, required 0", rx_busy); end
        checks++; if (accepts != a0 || rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_byte: got accepts=%0d valid=%0b, required %0d 0", accepts, rx_valid, a0); end
        step(BIT_CYC);
        push_exp(8'hA3);
        send_frame(8'hA3, BIT_CYC, 1'b1, BIT_CYC);
        step(10);
    endtask

    task automatic test_framing();
        int f0, v0;
        f0 = fe_count; v0 = valid_cycles;
        send_frame(8'hA5, BIT_CYC, 1'b0, 2 * BIT_CYC);
        rx = 1'b1;
        step(BIT_CYC);
        checks++; if (fe_count - f0 != 1) begin errors++; $display("FAIL framing_err_count: got %0d, required 1", fe_count - f0); end
        checks++; if (valid_cycles != v0) begin errors++; $display("FAIL framing_no_valid: got %0d valid cycles, required 0", valid_cycles - v0); end
        push_exp(8'h0F);
        send_frame(8'h0F, BIT_CYC, 1'b1, BIT_CYC);
        step(10);
    endtask

    task automatic test_overrun();
        int o0, a0;
        rx_ready = 1'b0;
        o0 = ov_count; a0 = accepts;
        push_exp(8'h11);
        send_frame(8'h11, BIT_CYC, 1'b1, BIT_CYC);
        send_frame(8'h22, BIT_CYC, 1'b1, BIT_CYC);
        step(BIT_CYC);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid_held: got %0b, required 1", rx_valid); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data_held: got %02h, required 11", rx_data); end
        checks++; if (ov_count - o0 != 1) begin errors++; $display("FAIL overrun_count: got %0d, required 1", ov_count - o0); end
        rx_ready = 1'b1;
        step(3);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_accept_clear: got %0b, required 0", rx_valid); end
        checks++; if (accepts - a0 != 1) begin errors++; $display("FAIL overrun_accepts: got %0d, required 1", accepts - a0); end
    endtask

    task automatic test_back_to_back();
        int a0, f0, o0;
        rx_ready = 1'b1;
        a0 = accepts; f0 = fe_count; o0 = ov_count;
        push_exp(8'h00);
        push_exp(8'hFF);
        send_frame(8'h00, SKEW_CYC, 1'b1, SKEW_CYC);
        send_frame(8'hFF, SKEW_CYC, 1'b1, SKEW_CYC);
        step(BIT_CYC);
        checks++; if (accepts - a0 != 2) begin errors++; $display("FAIL b2b_accepts: got %0d, required 2", accepts - a0); end
        checks++; if (fe_count != f0 || ov_count != o0) begin errors++; $display("FAIL b2b_errs: got fe=%0d ov=%0d, required 0 0", fe_count - f0, ov_count - o0); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        rx_ready = 1'b0;
        send_frame(8'h77, BIT_CYC, 1'b1, BIT_CYC);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_held_before: got %0b, required 1", rx_valid); end
        b = 8'h5A;
        rx = 1'b0;
        step(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            step(BIT_CYC);
        end
        rx = b[4];
        step(BIT_CYC / 2);
        rst = 1'b1;
        step(1);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b, required 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h, required 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b, required 0", rx_busy); end
        checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL midrst_pulses: got %02b, required 00", {frame_err, overrun}); end
        rst = 1'b0;
        rx = 1'b1;
        rx_ready = 1'b1;
        step(2 * BIT_CYC);
        push_exp(8'h3C);
        send_frame(8'h3C, BIT_CYC, 1'b1, BIT_CYC);
        step(10);
    endtask

    task automatic test_drain();
        step(2 * BIT_CYC);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_queue: got %0d pending, required 0", exp_q.size()); end
        checks++; if (accepts != pushed) begin errors++; $display("FAIL drain_total: got %0d accepts, required %0d", accepts, pushed); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
16x-oversampling UART receiver front end that sits directly upstream of the byte-buffering/echo stage. It synchronises the raw rx pin and detects and validates the start bit. It recovers 8N1 frames using 3-sample majority voting and presents each byte on a one-deep valid/ready output register. It also flags framing errors and overruns so the downstream stage no longer has to sample the pin itself.

Parameters:
FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line bit rate
OS, 16, oversampling ticks per bit (even, >= 8)
DIV, FREQ/(BAUD*OS) (= 78), clk cycles per oversample tick (integer truncation)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rx_data  out  8  received byte, LSB first on line; stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  downstream accepts rx_data when rx_valid & rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun  out  1  one-cycle pulse: completed byte dropped because holding register full
rx_busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst=1 at clk edge): sync flops=1, FSM=IDLE, tick divider=0, os_cnt=0, bit_idx=0, shift reg=0. Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0. Reset mid-frame discards the partial byte and any held byte.
- Input sync: 2-flop synchroniser; rx_s = second flop. All decisions use rx_s only; 2-cycle pin-to-logic latency.
- Tick: counter 0..DIV-1, tick=1 for one cycle when count==DIV-1. Forced to 0 on IDLE->START so bit phase aligns to the start edge.
- os_cnt 0..OS-1 increments on tick and wraps. Samples are taken at os_cnt = OS/2-1, OS/2, OS/2+1. Bit value = majority of the 3 samples, resolved on the tick at OS/2+1.
- FSM:
  IDLE: rx_s==0 -> START, os_cnt=0.
  START: majority resolves 1 (glitch) -> IDLE, no output. Resolves 0 -> continue to os_cnt wrap -> DATA, bit_idx=0.
  DATA: at majority resolve, shift bit into MSB (LSB-first recovery). At os_cnt wrap: bit_idx==7 -> STOP, else bit_idx+1.
  STOP: at majority resolve (mid stop bit, not end): value 1 -> deliver byte, go IDLE. Value 0 -> frame_err pulse, byte discarded, go WAIT_HI.
  WAIT_HI: stay until rx_s==1, then IDLE. A break condition produces exactly one frame_err.
- Delivery, in the cycle after the stop resolve:
  rx_valid=0, or (rx_valid & rx_ready): load rx_data, rx_valid=1, no overrun.
  rx_valid=1 & !rx_ready: keep the old byte, drop the new one, overrun pulse.
- Accept: rx_valid & rx_ready with no simultaneous delivery -> rx_valid=0 next cycle. rx_data holds its last value.
- Back-to-back frames: returning to IDLE at mid-stop lets a start bit immediately following the stop bit be caught. Tolerates about ±3% baud mismatch.
- rx_ready is ignored while rx_valid=0.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HI)
  - default FREQ/BAUD/OS constants
  - a function computing DIV and the counter width ($clog2(DIV))
- One sub-module, uart_baud_tick: parameterised divider with sync restart input and tick output. It is reused by the transmit side.

Test Plan:
1. FREQ=12M, BAUD=9600, send 0x55 8N1, rx_ready=1 -> single rx_valid cycle with rx_data=0x55; frame_err=0, overrun=0.
2. rx low for 20 clk (< half bit), then high -> no rx_valid; rx_busy returns 0 by tick OS/2+1; then 0xA3 received correctly.
3. Send 0xA5 with stop bit driven 0 for 2 bit times -> frame_err pulses exactly once, rx_valid stays 0; next 0x0F after line high received correctly.
4. rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid=1 with rx_data=0x11; overrun pulse at second stop; after rx_ready=1, one accept, rx_valid=0.
5. rx_ready=1, back-to-back 0x00, 0xFF with zero idle gap, and baud skewed +2.5% -> both bytes delivered in order, no errors.
6. Assert rst during bit 4 of a frame -> outputs at reset values next cycle. After line idle, 0x3C is received correctly.
